// File: rtl/maze_pkg.sv
// =====================================================================
// maze_pkg : shared types and direction helpers for maze_solver_param
// Rev 1.0
// =====================================================================
`default_nettype none

package maze_pkg;

  typedef enum logic [1:0] {
    DIR_L = 2'd0,
    DIR_D = 2'd1,
    DIR_R = 2'd2,
    DIR_U = 2'd3
  } dir_t;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    CHK0  = 4'd1,
    W0    = 4'd2,
    PROBE = 4'd3,
    WAIT  = 4'd4,
    POP   = 4'd5,
    DONE  = 4'd6,
    FAIL  = 4'd7,
    RUN   = 4'd8
  } state_t;

  // L<->R and D<->U differ only in bit 1
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  function automatic logic signed [1:0] row_step(input dir_t d);
    case (d)
      DIR_D:   return 2'sd1;
      DIR_U:   return -2'sd1;
      default: return 2'sd0;
    endcase
  endfunction

  function automatic logic signed [1:0] col_step(input dir_t d);
    case (d)
      DIR_R:   return 2'sd1;
      DIR_L:   return -2'sd1;
      default: return 2'sd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/maze_solver_param_if.sv
// =====================================================================
// maze_solver_param_if : control, maze RAM and move-stream bundle
// Rev 1.0
// =====================================================================
`default_nettype none

interface maze_solver_param_if #(
  parameter int AW = 4,
  parameter int SW = 5
);
  logic          start;
  logic          run;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wall;
  logic          busy;
  logic          done;
  logic          fail;
  logic          move_valid;
  logic [1:0]    move_dir;
  logic [SW-1:0] path_len;

  modport master (
    input  start, run, mem_wall,
    output mem_addr, mem_rd, busy, done, fail, move_valid, move_dir, path_len
  );

  modport slave (
    output start, run, mem_wall,
    input  mem_addr, mem_rd, busy, done, fail, move_valid, move_dir, path_len
  );
endinterface

`default_nettype wire

// File: rtl/maze_solver_param_dir_stack.sv
// =====================================================================
// dir_stack : 2-bit LIFO holding the solution path, with replay read port
// Rev 1.0
// =====================================================================
`default_nettype none

module dir_stack
  import maze_pkg::*;
#(
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  dir_t          push_data,
  input  logic [SW-1:0] rd_idx,
  output dir_t          rd_data,
  output dir_t          top_data,
  output logic [SW-1:0] sp
);
  // Power-of-two storage so every SW-bit index is in range; depth >= ROWS*COLS
  localparam int DEPTH = 1 << SW;

  dir_t mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (push) begin
      sp <= sp + SW'(1);
    end else if (pop) begin
      sp <= sp - SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[sp] <= push_data;
    end
  end

  assign rd_data  = mem[rd_idx];
  assign top_data = mem[sp - SW'(1)];

endmodule

`default_nettype wire

// File: rtl/maze_solver_param.sv
// =====================================================================
// maze_solver_param : DFS rat-in-maze solver over external RAM, path replay
// Rev 1.0
// =====================================================================
`default_nettype none

module maze_solver_param
  import maze_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int AW   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
  parameter int SW   = $clog2(ROWS * COLS + 1)
) (
  input logic                 clk,
  input logic                 rst,
  maze_solver_param_if.master bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int VN = 1 << AW;

  state_t        state, state_nx;
  logic [RW-1:0] row, nb_row, bk_row;
  logic [CW-1:0] col, nb_col, bk_col;
  logic [2:0]    dir;
  logic [VN-1:0] visited;
  logic [SW-1:0] ridx, sp;
  logic [AW-1:0] nb_addr, rd_addr;
  logic          nb_ok, nb_goal, probe_go, launch, replay, push, pop, rd;
  dir_t          probe_d, top_d, rep_d;

  assign probe_d = dir_t'(dir[1:0]);

  always_comb begin
    nb_row = row + RW'(row_step(probe_d));
    nb_col = col + CW'(col_step(probe_d));
    case (probe_d)
      DIR_L:   nb_ok = (col != '0);
      DIR_D:   nb_ok = (int'(row) < ROWS - 1);
      DIR_R:   nb_ok = (int'(col) < COLS - 1);
      default: nb_ok = (row != '0);
    endcase
  end

  assign nb_addr  = AW'(int'(nb_row) * COLS + int'(nb_col));
  assign nb_goal  = (int'(nb_row) == ROWS - 1) && (int'(nb_col) == COLS - 1);
  assign probe_go = !dir[2] && nb_ok && !visited[nb_addr];

  // Backtracking undoes the popped move
  assign bk_row = row + RW'(row_step(opposite(top_d)));
  assign bk_col = col + CW'(col_step(opposite(top_d)));

  assign launch = bus.start && (state == IDLE || state == DONE || state == FAIL);
  assign replay = bus.run && !bus.start && (state == DONE);
  assign push   = (state == WAIT) && !bus.mem_wall;
  assign pop    = (state == POP) && (sp != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rd       = 1'b0;
    rd_addr  = '0;
    case (state)
      IDLE, FAIL: begin
        if (launch) state_nx = CHK0;
      end
      DONE: begin
        if (launch)      state_nx = CHK0;
        else if (replay) state_nx = RUN;
      end
      CHK0: begin
        rd       = 1'b1;
        state_nx = W0;
      end
      W0: begin
        if (bus.mem_wall)         state_nx = FAIL;
        else if (ROWS * COLS == 1) state_nx = DONE;
        else                       state_nx = PROBE;
      end
      PROBE: begin
        if (dir[2]) begin
          state_nx = POP;
        end else if (probe_go) begin
          rd       = 1'b1;
          rd_addr  = nb_addr;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (!bus.mem_wall && nb_goal) state_nx = DONE;
        else                          state_nx = PROBE;
      end
      POP: begin
        state_nx = (sp == '0) ? FAIL : PROBE;
      end
      RUN: begin
        if (sp == '0 || ridx == sp - SW'(1)) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row     <= '0;
      col     <= '0;
      dir     <= '0;
      visited <= '0;
      ridx    <= '0;
    end else begin
      case (state)
        IDLE, DONE, FAIL: begin
          if (launch) begin
            row     <= '0;
            col     <= '0;
            dir     <= '0;
            visited <= '0;
          end else if (replay) begin
            ridx <= '0;
          end
        end
        W0: begin
          if (!bus.mem_wall) visited[0] <= 1'b1;
        end
        PROBE: begin
          if (!dir[2] && !probe_go) dir <= dir + 3'd1;
        end
        WAIT: begin
          if (bus.mem_wall) begin
            dir <= dir + 3'd1;
          end else begin
            row              <= nb_row;
            col              <= nb_col;
            visited[nb_addr] <= 1'b1;
            dir              <= '0;
          end
        end
        POP: begin
          if (sp != '0) begin
            row <= bk_row;
            col <= bk_col;
            dir <= {1'b0, top_d} + 3'd1;
          end
        end
        RUN: begin
          ridx <= ridx + SW'(1);
        end
        default: ;
      endcase
    end
  end

  dir_stack #(
    .SW(SW)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .clear    (launch),
    .push     (push),
    .pop      (pop),
    .push_data(probe_d),
    .rd_idx   (ridx),
    .rd_data  (rep_d),
    .top_data (top_d),
    .sp       (sp)
  );

  assign bus.mem_rd     = rd;
  assign bus.mem_addr   = rd_addr;
  assign bus.busy       = !(state == IDLE || state == DONE || state == FAIL);
  assign bus.done       = (state == DONE) || (state == RUN);
  assign bus.fail       = (state == FAIL);
  assign bus.move_valid = (state == RUN) && (sp != '0);
  assign bus.move_dir   = bus.move_valid ? rep_d : DIR_L;
  assign bus.path_len   = sp;

endmodule

`default_nettype wire

// File: tb/tb_maze_solver_param.sv
// =====================================================================
// tb_maze_solver_param : directed scoreboard bench for maze_solver_param
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_maze_solver_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  maze_solver_param_if #(.AW(4), .SW(5)) bus ();
  maze_solver_param_if #(.AW(1), .SW(1)) bus1 ();

  maze_solver_param #(.ROWS(4), .COLS(4), .AW(4), .SW(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  maze_solver_param #(.ROWS(1), .COLS(1), .AW(1), .SW(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  logic [15:0] maze  = '0;
  logic        maze1 = 1'b0;

  // Single-port maze RAM: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (bus.mem_rd === 1'b1)  bus.mem_wall  <= maze[bus.mem_addr];
    if (bus1.mem_rd === 1'b1) bus1.mem_wall <= maze1;
  end

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_rd === 1'b1) rd_cnt++;
    if (bus.move_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("move_extra", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("move_dir", {30'd0, bus.move_dir}, {30'd0, mon_e});
      end
    end
    if (rst === 1'b1 && bus1.move_valid !== 1'b0) chk("move1_none", {31'd0, bus1.move_valid}, 32'd0);
  end

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic pulse_run();
    @(negedge clk); bus.run = 1'b1;
    @(negedge clk); bus.run = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(bus.done === 1'b1 || bus.fail === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, {31'd0, (n < 500)}, 32'd1);
  endtask

  task automatic replay(input int n, input string tag);
    pulse_run();
    repeat (n) @(negedge clk);
    #1;
    chk({tag, "_left"}, exp_q.size(), 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.run = 1'b0;
    bus1.start = 1'b0; bus1.run = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("rst_done",  {31'd0, bus.done}, 32'd0);
    chk("rst_fail",  {31'd0, bus.fail}, 32'd0);
    chk("rst_len",   {27'd0, bus.path_len}, 32'd0);
    chk("rst_rd",    {31'd0, bus.mem_rd}, 32'd0);
    chk("rst_valid", {31'd0, bus.move_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // run while idle does nothing
    pulse_run();
    @(negedge clk);
    chk("idle_run_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_run_done", {31'd0, bus.done}, 32'd0);

    // open maze: straight down then right
    maze = '0;
    rd_cnt = 0;
    pulse_start();
    wait_end("open");
    chk("open_done", {31'd0, bus.done}, 32'd1);
    chk("open_fail", {31'd0, bus.fail}, 32'd0);
    chk("open_len",  {27'd0, bus.path_len}, 32'd6);
    chk("open_reads", rd_cnt, 32'd7);
    exp_q = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    replay(6, "open_run1");

    // start during replay must not cut it short
    exp_q = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    @(negedge clk); bus.run = 1'b1;
    @(negedge clk); bus.run = 1'b0; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("run_start_left", exp_q.size(), 32'd0);
    chk("run_start_done", {31'd0, bus.done}, 32'd1);
    chk("run_start_len",  {27'd0, bus.path_len}, 32'd6);

    // walls at 5 and 8: first D branch dead-ends and is backtracked
    maze = 16'h0120;
    pulse_start();
    chk("w58_busy", {31'd0, bus.busy}, 32'd1);
    chk("w58_done_clr", {31'd0, bus.done}, 32'd0);
    wait_end("w58");
    chk("w58_done", {31'd0, bus.done}, 32'd1);
    chk("w58_len",  {27'd0, bus.path_len}, 32'd8);
    exp_q = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 2'd2};
    replay(8, "w58_run1");
    exp_q = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 2'd2};
    replay(8, "w58_run2");

    // walls at 1 and 4: start cell boxed in
    maze = 16'h0012;
    pulse_start();
    chk("box_done_clr", {31'd0, bus.done}, 32'd0);
    wait_end("box");
    chk("box_fail", {31'd0, bus.fail}, 32'd1);
    chk("box_done", {31'd0, bus.done}, 32'd0);
    pulse_run();
    @(negedge clk);
    chk("fail_run_fail", {31'd0, bus.fail}, 32'd1);
    chk("fail_run_busy", {31'd0, bus.busy}, 32'd0);

    // wall on the start cell: fail two cycles after start
    maze = 16'h0001;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    chk("w0_fail_early", {31'd0, bus.fail}, 32'd0);
    @(negedge clk);
    chk("w0_fail", {31'd0, bus.fail}, 32'd1);

    // asynchronous reset in PROBE at depth 3
    maze = '0;
    pulse_start();
    n = 0;
    while (bus.path_len !== 5'd3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sp3_reached", {31'd0, (n < 200)}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("arst_done",  {31'd0, bus.done}, 32'd0);
    chk("arst_len",   {27'd0, bus.path_len}, 32'd0);
    chk("arst_rd",    {31'd0, bus.mem_rd}, 32'd0);
    @(negedge clk); rst = 1'b1;
    pulse_start();
    wait_end("resolve");
    chk("resolve_done", {31'd0, bus.done}, 32'd1);
    chk("resolve_len",  {27'd0, bus.path_len}, 32'd6);
    exp_q = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    replay(6, "resolve_run");

    // 1x1 maze: solved with an empty path, replay emits nothing
    @(negedge clk); bus1.start = 1'b1;
    @(negedge clk); bus1.start = 1'b0;
    n = 0;
    while (bus1.done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("one_done", {31'd0, bus1.done}, 32'd1);
    chk("one_len",  {31'd0, bus1.path_len}, 32'd0);
    chk("one_fail", {31'd0, bus1.fail}, 32'd0);
    @(negedge clk); bus1.run = 1'b1;
    @(negedge clk); bus1.run = 1'b0;
    repeat (3) @(negedge clk);
    chk("one_run_done", {31'd0, bus1.done}, 32'd1);
    chk("one_run_busy", {31'd0, bus1.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
